mem_responder: RTL and testbench

//  Memory-side responder for the processor's data/instruction bus: accepts a request

---
 rtl/mem_responder_pkg.sv | 22 ++
 rtl/mem_responder_mem_array.sv | 40 ++++
 rtl/mem_responder.sv | 176 +++++++++++++++++
 tb/tb_mem_responder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: bus width default, responder FSM state encoding,
// wait-counter width and the address range helper.
package mem_responder_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int CNT_W      = 4;

    localparam logic [CNT_W-1:0] CNT_ZERO = 4'd0;
    localparam logic [CNT_W-1:0] CNT_ONE  = 4'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // True when a word address falls inside the populated RAM.
    function automatic logic addr_in_range(input logic [31:0] a, input logic [31:0] depth);
        return (a < depth) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// mem_array: single-port synchronous word RAM with a registered read port.
// Reset clears only the read register; stored words survive reset.
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 128,
    parameter int IDX_W  = 7
) (
    input  logic              clock,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage write port; contents are never cleared.
    always_ff @(posedge clock) begin
        if (en_i && we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    // Read register: loads only on reads, so writes and idle cycles hold it.
    always_ff @(posedge clock) begin
        if (rst_i) begin
            rdata_q <= {DATA_W{1'b0}};
        end else if (en_i && !we_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// mem_responder: processor-bus memory responder with programmable wait states.
// Optional feature macro: MEM_ADDR_CHECK_EN (out-of-range addresses flagged and
// suppressed instead of wrapping modulo DEPTH).
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = 7,
    parameter int DEPTH       = 128,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              w_d,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              busy,
    output logic              err_ovr,
    output logic              err_addr
);

    localparam int               IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);
    localparam logic             NO_WAIT = (WAIT_CYCLES == 0) ? 1'b1 : 1'b0;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wr_q;
    logic              ack_q;
    logic              busy_q;
    logic              err_ovr_q;

    logic              accept_s;
    logic              access_s;
    logic [ADDR_W-1:0] acc_addr_s;
    logic [DATA_W-1:0] acc_wdata_s;
    logic              acc_wr_s;
    logic              acc_ok_s;
    logic              ram_en_s;
    logic [IDX_W-1:0]  ram_idx_s;
    logic [DATA_W-1:0] ram_rdata_s;

    assign accept_s = req && (state_q != ST_WAIT);

    // Select the access performed on this edge: live bus when there are no
    // wait states, otherwise the latched request on its last wait cycle.
    always_comb begin
        access_s    = 1'b0;
        acc_addr_s  = addr_q;
        acc_wdata_s = wdata_q;
        acc_wr_s    = wr_q;
        if (accept_s && NO_WAIT) begin
            access_s    = 1'b1;
            acc_addr_s  = addr;
            acc_wdata_s = wdata;
            acc_wr_s    = w_d;
        end else if ((state_q == ST_WAIT) && (cnt_q == CNT_ONE)) begin
            access_s    = 1'b1;
        end else begin
            access_s    = 1'b0;
        end
`ifdef MEM_ADDR_CHECK_EN
        acc_ok_s  = addr_in_range(32'(acc_addr_s), 32'(DEPTH));
`else
        acc_ok_s  = 1'b1;
`endif
        // Reset on the same edge cancels the access.
        ram_en_s  = access_s && acc_ok_s && !resetn;
        ram_idx_s = IDX_W'(32'(acc_addr_s) % 32'(DEPTH));
    end

    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clock   (clock),
        .rst_i   (resetn),
        .en_i    (ram_en_s),
        .we_i    (acc_wr_s),
        .idx_i   (ram_idx_s),
        .wdata_i (acc_wdata_s),
        .rdata_o (ram_rdata_s)
    );

    // Request FSM: accept/latch, wait countdown, one-cycle ack and overrun flag.
    always_ff @(posedge clock) begin
        if (resetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_ZERO;
            addr_q    <= {ADDR_W{1'b0}};
            wdata_q   <= {DATA_W{1'b0}};
            wr_q      <= 1'b0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            err_ovr_q <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            if ((state_q == ST_WAIT) && req) begin
                err_ovr_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE, ST_RESP: begin
                    if (req) begin
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        wr_q    <= w_d;
                        if (NO_WAIT) begin
                            state_q <= ST_RESP;
                            ack_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= WAIT_LD;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == CNT_ONE) begin
                        state_q <= ST_RESP;
                        cnt_q   <= CNT_ZERO;
                        ack_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= CNT_ZERO;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_ADDR_CHECK_EN
    logic rd_zero_q;
    logic err_addr_q;

    // Out-of-range tracking: zero the read data and raise the sticky flag.
    always_ff @(posedge clock) begin
        if (resetn) begin
            rd_zero_q  <= 1'b0;
            err_addr_q <= 1'b0;
        end else begin
            if (access_s && !acc_wr_s) begin
                rd_zero_q <= !acc_ok_s;
            end
            if (access_s && !acc_ok_s) begin
                err_addr_q <= 1'b1;
            end
        end
    end

    assign rdata    = rd_zero_q ? {DATA_W{1'b0}} : ram_rdata_s;
    assign err_addr = err_addr_q;
`else
    assign rdata    = ram_rdata_s;
    assign err_addr = 1'b0;
`endif

    assign ack     = ack_q;
    assign busy    = busy_q;
    assign err_ovr = err_ovr_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: two responders share one bus, A with no wait states and
// DEPTH=100, B with three wait states and DEPTH=128. A transaction-level model
// predicts each output every cycle; directed steps add literal expectations.
module tb_mem_responder;

    logic        clock;
    logic        resetn;
    logic        req;
    logic [6:0]  addr;
    logic [15:0] wdata;
    logic        w_d;

    logic [15:0] rdata_a, rdata_b;
    logic        ack_a, ack_b, busy_a, busy_b;
    logic        ovr_a, ovr_b, eaddr_a, eaddr_b;

    mem_responder #(.DATA_W(16), .ADDR_W(7), .DEPTH(100), .WAIT_CYCLES(0)) dut_a (
        .clock(clock), .resetn(resetn), .req(req), .addr(addr), .wdata(wdata), .w_d(w_d),
        .rdata(rdata_a), .ack(ack_a), .busy(busy_a), .err_ovr(ovr_a), .err_addr(eaddr_a)
    );

    mem_responder #(.DATA_W(16), .ADDR_W(7), .DEPTH(128), .WAIT_CYCLES(3)) dut_b (
        .clock(clock), .resetn(resetn), .req(req), .addr(addr), .wdata(wdata), .w_d(w_d),
        .rdata(rdata_b), .ack(ack_b), .busy(busy_b), .err_ovr(ovr_b), .err_addr(eaddr_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_checks = 0;
    int n_errors = 0;
    logic cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_wait [2] = '{0, 3};
    int          m_depth[2] = '{100, 128};
    logic [15:0] m_mem  [2][128];
    logic [15:0] m_rdata[2];
    logic        m_ack[2], m_busy[2], m_ovr[2], m_eaddr[2];
    logic        m_pv[2], m_pw[2];
    int          m_due[2];
    logic [6:0]  m_pa[2];
    logic [15:0] m_pd[2];
    int          edge_n;

    task automatic m_access(input int u, input logic wr, input logic [6:0] a, input logic [15:0] d);
        logic ok;
        int   idx;
        ok = 1'b1;
`ifdef MEM_ADDR_CHECK_EN
        ok = (int'(a) < m_depth[u]);
`endif
        if (!ok) begin
            m_eaddr[u] = 1'b1;
            if (!wr) m_rdata[u] = 16'h0000;
        end else begin
            idx = int'(a) % m_depth[u];
            if (wr) m_mem[u][idx] = d;
            else    m_rdata[u] = m_mem[u][idx];
        end
    endtask

    initial begin
        edge_n = 0;
        for (int u = 0; u < 2; u++) begin
            m_rdata[u] = 16'h0000; m_ack[u] = 1'b0; m_busy[u] = 1'b0;
            m_ovr[u] = 1'b0; m_eaddr[u] = 1'b0; m_pv[u] = 1'b0;
        end
        forever begin
            @(posedge clock);
            edge_n++;
            for (int u = 0; u < 2; u++) begin
                if (resetn) begin
                    m_rdata[u] = 16'h0000; m_ack[u] = 1'b0; m_busy[u] = 1'b0;
                    m_ovr[u] = 1'b0; m_eaddr[u] = 1'b0; m_pv[u] = 1'b0;
                end else begin
                    m_ack[u] = 1'b0;
                    if (m_pv[u]) begin
                        if (req) m_ovr[u] = 1'b1;
                        if (edge_n == m_due[u]) begin
                            m_access(u, m_pw[u], m_pa[u], m_pd[u]);
                            m_ack[u] = 1'b1;
                            m_pv[u]  = 1'b0;
                        end
                    end else if (req) begin
                        if (m_wait[u] == 0) begin
                            m_access(u, w_d, addr, wdata);
                            m_ack[u] = 1'b1;
                        end else begin
                            m_pv[u] = 1'b1; m_due[u] = edge_n + m_wait[u];
                            m_pa[u] = addr; m_pw[u] = w_d; m_pd[u] = wdata;
                        end
                    end
                    m_busy[u] = m_pv[u];
                end
            end
        end
    end

    // Per-cycle comparison of both responders against the model.
    initial begin
        forever begin
            @(negedge clock);
            if (cmp_en) begin
                chk("A.rdata",    32'(rdata_a), 32'(m_rdata[0]));
                chk("A.ack",      32'(ack_a),   32'(m_ack[0]));
                chk("A.busy",     32'(busy_a),  32'(m_busy[0]));
                chk("A.err_ovr",  32'(ovr_a),   32'(m_ovr[0]));
                chk("A.err_addr", 32'(eaddr_a), 32'(m_eaddr[0]));
                chk("B.rdata",    32'(rdata_b), 32'(m_rdata[1]));
                chk("B.ack",      32'(ack_b),   32'(m_ack[1]));
                chk("B.busy",     32'(busy_b),  32'(m_busy[1]));
                chk("B.err_ovr",  32'(ovr_b),   32'(m_ovr[1]));
                chk("B.err_addr", 32'(eaddr_b), 32'(m_eaddr[1]));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    // One-cycle request strobe; afterwards the bus is scrambled to prove latching.
    task automatic bus(input logic wr, input logic [6:0] a, input logic [15:0] d);
        req = 1'b1; w_d = wr; addr = a; wdata = d;
        @(negedge clock);
        req = 1'b0; w_d = ~wr; addr = ~a; wdata = ~d;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        resetn = 1'b1; req = 1'b0; addr = 7'd0; wdata = 16'h0000; w_d = 1'b0;
        idle(3);
        cmp_en = 1'b1;
        chk("reset A.rdata", 32'(rdata_a), 32'h0);
        chk("reset A.ack",   32'(ack_a),   32'h0);
        chk("reset B.busy",  32'(busy_b),  32'h0);
        resetn = 1'b0;
        idle(1);

        // Zero-wait write then read of address 5.
        bus(1'b1, 7'd5, 16'h1234);
        chk("t1 A write ack", 32'(ack_a), 32'h1);
        chk("t1 B busy",      32'(busy_b), 32'h1);
        idle(3);
        chk("t1 B write ack", 32'(ack_b), 32'h1);
        idle(2);
        bus(1'b0, 7'd5, 16'h0000);
        chk("t1 A read ack",   32'(ack_a),   32'h1);
        chk("t1 A read rdata", 32'(rdata_a), 32'h1234);
        idle(3);
        chk("t1 B read rdata", 32'(rdata_b), 32'h1234);
        idle(2);

        // Request while B is waiting: overrun, no extra ack.
        bus(1'b0, 7'd5, 16'h0000);
        chk("t2 B busy", 32'(busy_b), 32'h1);
        idle(1);
        bus(1'b0, 7'd5, 16'h0000);
        chk("t2 B err_ovr", 32'(ovr_b), 32'h1);
        chk("t2 B early ack", 32'(ack_b), 32'h0);
        idle(1);
        chk("t2 B ack", 32'(ack_b), 32'h1);
        idle(1);
        chk("t2 B no extra ack", 32'(ack_b), 32'h0);
        chk("t2 A err_ovr", 32'(ovr_a), 32'h0);
        idle(2);

        // Back-to-back on A: read issued in the RESP cycle of the write.
        req = 1'b1; w_d = 1'b1; addr = 7'd9; wdata = 16'hBEEF;
        @(negedge clock);
        chk("t3 A write ack", 32'(ack_a), 32'h1);
        w_d = 1'b0; wdata = 16'h0000;
        @(negedge clock);
        req = 1'b0;
        chk("t3 A read ack",   32'(ack_a),   32'h1);
        chk("t3 A read rdata", 32'(rdata_a), 32'hBEEF);
        idle(5);

        // Back-to-back on B: read request in B's RESP cycle.
        bus(1'b1, 7'd12, 16'hC3C3);
        idle(3);
        chk("t3 B write ack", 32'(ack_b), 32'h1);
        bus(1'b0, 7'd12, 16'h0000);
        idle(3);
        chk("t3 B b2b ack",   32'(ack_b),   32'h1);
        chk("t3 B b2b rdata", 32'(rdata_b), 32'hC3C3);
        idle(2);

        // Reset during B's wait drops the pending write.
        bus(1'b1, 7'd3, 16'h0A0A);
        idle(5);
        bus(1'b1, 7'd3, 16'h5555);
        resetn = 1'b1;
        @(negedge clock);
        resetn = 1'b0;
        chk("t4 B busy",    32'(busy_b),  32'h0);
        chk("t4 B rdata",   32'(rdata_b), 32'h0);
        chk("t4 B err_ovr", 32'(ovr_b),   32'h0);
        idle(4);
        bus(1'b0, 7'd3, 16'h0000);
        chk("t4 A rdata", 32'(rdata_a), 32'h5555);
        idle(3);
        chk("t4 B ack",   32'(ack_b),   32'h1);
        chk("t4 B rdata", 32'(rdata_b), 32'h0A0A);
        idle(2);

        // Address beyond DEPTH=100 on A.
        bus(1'b1, 7'd20, 16'h2020);
        idle(5);
        bus(1'b1, 7'd120, 16'h7777);
        idle(5);
        bus(1'b0, 7'd120, 16'h0000);
        chk("t5 A ack", 32'(ack_a), 32'h1);
`ifdef MEM_ADDR_CHECK_EN
        chk("t5 A rdata@120",  32'(rdata_a), 32'h0);
        chk("t5 A err_addr",   32'(eaddr_a), 32'h1);
`else
        chk("t5 A rdata@120",  32'(rdata_a), 32'h7777);
        chk("t5 A err_addr",   32'(eaddr_a), 32'h0);
`endif
        idle(5);
        bus(1'b0, 7'd20, 16'h0000);
`ifdef MEM_ADDR_CHECK_EN
        chk("t5 A rdata@20", 32'(rdata_a), 32'h2020);
`else
        chk("t5 A rdata@20", 32'(rdata_a), 32'h7777);
`endif
        idle(4);
        chk("t5 B rdata@20", 32'(rdata_b), 32'h2020);
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
